sll_64b_arb: RTL and testbench

// Shares one sll_64b 64-bit logical-left-shift datapath among N_REQ requesters.
// - Round-robin arbitration picks one requester per transaction.
// - The block drives the shifter's init_i, waits for done_o, and returns the result tagged with the requester index.
// - Only one transaction is in flight at a time.
// - The block sits between client engines and a single instantiated sll_64b.

---
 rtl/sll_64b_arb.sv | 209 ++++++++++++++++++++
 tb/tb_sll_64b_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sll_64b_arb.sv
// sll_64b_arb: round-robin arbiter sharing one 64-bit logical-left-shift
// datapath (sll_64b) among N_REQ requesters, one transaction in flight.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   req_valid_i/ready_o     per-requester request handshake (ready one-hot)
//   req_shift_i/req_data_i  packed per-requester shift (6b) and operand (64b)
//   rsp_valid_o/ready_i     result handshake
//   rsp_id_o/rsp_data_o     owning requester index and shifted result
//   busy_o                  high whenever a transaction is in progress
//
// Build option: define SLL_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins, no rotating pointer); default is round-robin.

module sll_64b #(
    parameter logic OUT_REG = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        init_i,
    input  logic [5:0]  shift_i,
    input  logic [63:0] data_i,
    output logic        done_o,
    output logic [63:0] data_o
);
    if (OUT_REG) begin : g_reg
        logic        done_q, done_d;
        logic [63:0] res_q, res_d;

        always_comb begin
            done_d = init_i;
            res_d  = res_q;
            if (init_i) res_d = data_i << shift_i;
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                done_q <= 1'b0;
                res_q  <= '0;
            end else begin
                done_q <= done_d;
                res_q  <= res_d;
            end
        end

        assign done_o = done_q;
        assign data_o = res_q;
    end else begin : g_comb
        assign done_o = init_i;
        assign data_o = data_i << shift_i;
    end
endmodule

module sll_64b_arb #(
    parameter int   N_REQ   = 4,
    parameter logic OUT_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [6*N_REQ-1:0]       req_shift_i,
    input  logic [64*N_REQ-1:0]      req_data_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic [63:0]              rsp_data_o,
    output logic                     busy_o
);
    localparam int IDW = $clog2(N_REQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [5:0]       shift_q, shift_d;
    logic [63:0]      opnd_q, opnd_d;
    logic [63:0]      rsp_data_q, rsp_data_d;

    logic             win_vld;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   idx;
    logic [N_REQ-1:0] grant;
    logic             sh_init;
    logic             sh_done;
    logic [63:0]      sh_data;

`ifndef SLL_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   ptr_q, ptr_d;
    int               j;
`endif

    // Winner search: first valid bit starting at ptr, wrapping at N_REQ-1.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
`ifndef SLL_ARB_FIXED_PRIO_EN
        j       = 0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
`ifdef SLL_ARB_FIXED_PRIO_EN
            idx = IDW'(i);
`else
            j = int'(ptr_q) + i;
            if (j >= N_REQ) j = j - N_REQ;
            idx = IDW'(j);
`endif
            if (!win_vld && req_valid_i[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        shift_d    = shift_q;
        opnd_d     = opnd_q;
        rsp_data_d = rsp_data_q;
        grant      = '0;
        sh_init    = 1'b0;
`ifndef SLL_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    id_d    = win_id;
                    state_d = EXEC;
                    for (int k = 0; k < N_REQ; k++) begin
                        if (win_id == IDW'(k)) begin
                            grant[k] = 1'b1;
                            shift_d  = req_shift_i[6*k +: 6];
                            opnd_d   = req_data_i[64*k +: 64];
                        end
                    end
`ifndef SLL_ARB_FIXED_PRIO_EN
                    ptr_d = (win_id == IDW'(N_REQ-1)) ? '0 : win_id + 1'b1;
`endif
                end
            end
            EXEC: begin
                sh_init = 1'b1;
                if (OUT_REG) begin
                    state_d = WAIT;
                end else begin
                    rsp_data_d = sh_data;
                    state_d    = RESP;
                end
            end
            WAIT: begin
                if (sh_done) begin
                    rsp_data_d = sh_data;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            id_q       <= '0;
            shift_q    <= '0;
            opnd_q     <= '0;
            rsp_data_q <= '0;
`ifndef SLL_ARB_FIXED_PRIO_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            shift_q    <= shift_d;
            opnd_q     <= opnd_d;
            rsp_data_q <= rsp_data_d;
`ifndef SLL_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    sll_64b #(
        .OUT_REG (OUT_REG)
    ) u_sll (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (sh_init),
        .shift_i (shift_q),
        .data_i  (opnd_q),
        .done_o  (sh_done),
        .data_o  (sh_data)
    );

    // Grant is combinational from IDLE; masked so it reads 0 while in reset.
    assign req_ready_o = grant & {N_REQ{rst_n_i}};
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_sll_64b_arb.sv
// tb_sll_64b_arb: two arbiter instances (registered and combinational
// shifter) driven by directed vectors and checked against a cycle model.

module tb_sll_64b_arb;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][3:0]  vld;
    logic [1:0][23:0] shv;
    logic [1:0][255:0] dv;
    logic [1:0]       rrdy;
    logic [1:0][3:0]  rdy;
    logic [1:0]       rv;
    logic [1:0][1:0]  rid;
    logic [1:0][63:0] rdat;
    logic [1:0]       bsy;

    int ncmp = 0;
    int nerr = 0;

    int          m_phase [2];
    int          m_ptr   [2];
    logic [1:0]  m_id    [2];
    logic [63:0] m_data  [2];

    always #5 clk = ~clk;

    sll_64b_arb #(.N_REQ(4), .OUT_REG(1'b1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
        .req_shift_i(shv[0]), .req_data_i(dv[0]),
        .rsp_valid_o(rv[0]), .rsp_ready_i(rrdy[0]),
        .rsp_id_o(rid[0]), .rsp_data_o(rdat[0]), .busy_o(bsy[0])
    );

    sll_64b_arb #(.N_REQ(4), .OUT_REG(1'b0)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
        .req_shift_i(shv[1]), .req_data_i(dv[1]),
        .rsp_valid_o(rv[1]), .rsp_ready_i(rrdy[1]),
        .rsp_id_o(rid[1]), .rsp_data_o(rdat[1]), .busy_o(bsy[1])
    );

    task automatic chk(input bit s, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %h want %h", nm, s, act, exp);
        end
    endtask

    // Cycle model: after a grant the response appears LAT cycles later
    // and stays until accepted; grants only happen while idle.
    initial begin
        bit          si;
        int          lat, w, j;
        logic [3:0]  t4, er;
        logic [255:0] t256;
        logic [23:0] t24;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                si  = s[0];
                lat = si ? 2 : 3;
                if (!rst_n) begin
                    chk(si, "rst_ready", 64'(rdy[si]), 64'h0);
                    chk(si, "rst_valid", 64'(rv[si]), 64'h0);
                    chk(si, "rst_id", 64'(rid[si]), 64'h0);
                    chk(si, "rst_data", rdat[si], 64'h0);
                    chk(si, "rst_busy", 64'(bsy[si]), 64'h0);
                    m_phase[si] = 0;
                    m_ptr[si]   = 0;
                end else begin
                    w = -1;
                    for (int i = 0; i < 4; i++) begin
                        j  = (m_ptr[si] + i) % 4;
                        t4 = vld[si] >> j;
                        if (w < 0 && t4[0]) w = j;
                    end
                    er = (m_phase[si] == 0 && w >= 0) ? (4'b0001 << w) : 4'b0000;
                    chk(si, "req_ready", 64'(rdy[si]), 64'(er));
                    chk(si, "busy", 64'(bsy[si]), 64'(m_phase[si] != 0));
                    chk(si, "rsp_valid", 64'(rv[si]), 64'(m_phase[si] == lat));
                    if (m_phase[si] == lat) begin
                        chk(si, "rsp_id", 64'(rid[si]), 64'(m_id[si]));
                        chk(si, "rsp_data", rdat[si], m_data[si]);
                    end
                    if (m_phase[si] == 0) begin
                        if (w >= 0) begin
                            t256 = dv[si] >> (64 * w);
                            t24  = shv[si] >> (6 * w);
                            m_id[si]    = w[1:0];
                            m_data[si]  = t256[63:0] << t24[5:0];
                            m_phase[si] = 1;
`ifndef SLL_ARB_FIXED_PRIO_EN
                            m_ptr[si]   = (w + 1) % 4;
`endif
                        end
                    end else if (m_phase[si] < lat) begin
                        m_phase[si] = m_phase[si] + 1;
                    end else if (rrdy[si]) begin
                        m_phase[si] = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit s, input logic [1:0] k,
                       input logic [5:0] sh, input logic [63:0] d);
        shv[s] = (shv[s] & ~(24'h3F << (6 * k))) | (24'(sh) << (6 * k));
        dv[s]  = (dv[s] & ~(256'(64'hFFFF_FFFF_FFFF_FFFF) << (64 * k)))
               | (256'(d) << (64 * k));
    endtask

    task automatic wait_grant(input bit s, output logic [3:0] g);
        g = 4'b0;
        for (int n = 0; n < 30 && g == 4'b0; n++) begin
            @(negedge clk);
            g = rdy[s];
        end
    endtask

    task automatic wait_idle(input bit s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bsy[s] && n < 40);
        chk(s, "idle_timeout", 64'(bsy[s]), 64'h0);
    endtask

    task automatic txn(input bit s, input logic [1:0] k,
                       input logic [5:0] sh, input logic [63:0] d,
                       output logic [3:0] g, output int lat,
                       output logic [1:0] id, output logic [63:0] dat);
        put(s, k, sh, d);
        step();
        vld[s] = vld[s] | (4'b0001 << k);
        wait_grant(s, g);
        step();
        vld[s] = vld[s] & ~(4'b0001 << k);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv[s] && lat < 20);
        id  = rid[s];
        dat = rdat[s];
        wait_idle(s);
    endtask

    initial begin
        logic [3:0]  g;
        logic [1:0]  id;
        logic [63:0] dat;
        int          lat, cnt, n;
        int          ord [5];
        int          exp_ord [5];
        bit          s;

`ifdef SLL_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0};
`endif
        rst_n = 1'b0;
        vld   = '0;
        shv   = '0;
        dv    = '0;
        rrdy  = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk(0, "reset_busy", 64'(bsy[0]), 64'h0);
        chk(1, "reset_data", rdat[1], 64'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        for (int si = 0; si < 2; si++) begin
            s = si[0];

            txn(s, 2'd2, 6'd4, 64'h1, g, lat, id, dat);
            chk(s, "s1_grant", 64'(g), 64'h4);
            chk(s, "s1_latency", 64'(lat), s ? 64'd2 : 64'd3);
            chk(s, "s1_id", 64'(id), 64'd2);
            chk(s, "s1_data", dat, 64'h10);

            // Restart from ptr=0 so the rotation starts at requester 0.
            step();
            #2;
            rst_n = 1'b0;
            step();
            #2;
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++)
                put(s, 2'(k), 6'(k + 1), 64'h100 + 64'(k));
            step();
            vld[s] = 4'hF;
            cnt = 0;
            n   = 0;
            while (cnt < 5 && n < 60) begin
                @(negedge clk);
                n++;
                if (rdy[s] != 4'b0) begin
                    for (int k = 0; k < 4; k++)
                        if (rdy[s] == (4'b0001 << k)) ord[cnt] = k;
                    cnt++;
                end
            end
            step();
            vld[s] = 4'h0;
            wait_idle(s);
            chk(s, "rr_count", 64'(cnt), 64'd5);
            for (int i = 0; i < 5; i++)
                chk(s, "rr_order", 64'(ord[i]), 64'(exp_ord[i]));

            txn(s, 2'd3, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, g, lat, id, dat);
            chk(s, "s63_data", dat, 64'h8000_0000_0000_0000);
            chk(s, "s63_id", 64'(id), 64'd3);

            txn(s, 2'd0, 6'd0, 64'hDEAD_BEEF_0123_4567, g, lat, id, dat);
            chk(s, "s0_data", dat, 64'hDEAD_BEEF_0123_4567);

            rrdy[s] = 1'b0;
            put(s, 2'd0, 6'd8, 64'h12);
            put(s, 2'd1, 6'd1, 64'h5);
            step();
            vld[s] = 4'b0001;
            wait_grant(s, g);
            step();
            vld[s] = 4'b0010;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rv[s] && n < 20);
            for (int c = 0; c < 10; c++) begin
                chk(s, "stall_ready", 64'(rdy[s]), 64'h0);
                chk(s, "stall_data", rdat[s], 64'h1200);
                chk(s, "stall_id", 64'(rid[s]), 64'h0);
                @(negedge clk);
            end
            step();
            rrdy[s] = 1'b1;
            @(negedge clk);
            chk(s, "stall_last", 64'(rv[s]), 64'h1);
            @(negedge clk);
            chk(s, "post_stall_grant", 64'(rdy[s]), 64'h2);
            step();
            vld[s] = 4'b0;
            wait_idle(s);

            txn(s, 2'd1, 6'd2, 64'h3, g, lat, id, dat);
            put(s, 2'd2, 6'd5, 64'h7);
            step();
            vld[s] = 4'b0100;
            wait_grant(s, g);
            step();
            vld[s] = 4'b0;
            if (!s) step();
            #2;
            rst_n = 1'b0;
            vld[s] = 4'b1010;
            put(s, 2'd1, 6'd3, 64'h9);
            put(s, 2'd3, 6'd3, 64'hA);
            #1;
            chk(s, "mid_rst_busy", 64'(bsy[s]), 64'h0);
            chk(s, "mid_rst_ready", 64'(rdy[s]), 64'h0);
            chk(s, "mid_rst_valid", 64'(rv[s]), 64'h0);
            chk(s, "mid_rst_data", rdat[s], 64'h0);
            step();
            #2;
            rst_n = 1'b1;
            @(negedge clk);
            chk(s, "post_rst_grant", 64'(rdy[s]), 64'h2);
            chk(s, "post_rst_valid", 64'(rv[s]), 64'h0);
            step();
            vld[s] = 4'b1000;
            wait_grant(s, g);
            step();
            vld[s] = 4'b0;
            wait_idle(s);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
